// File: rtl/pipelined_decode_stage_pkg.sv
// ISA constants, field positions, control-bit layout and FSM encoding for the decode stage.
package protocore_isa_pkg;

  localparam int unsigned OPC_W    = 4;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned CTRL_W   = 9;
  localparam int unsigned CNT_W    = 3;

  localparam logic [OPC_W-1:0] OP_ADD   = 4'h0;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h1;
  localparam logic [OPC_W-1:0] OP_AND   = 4'h2;
  localparam logic [OPC_W-1:0] OP_OR    = 4'h3;
  localparam logic [OPC_W-1:0] OP_XOR   = 4'h4;
  localparam logic [OPC_W-1:0] OP_NOT   = 4'h5;
  localparam logic [OPC_W-1:0] OP_SHL   = 4'h6;
  localparam logic [OPC_W-1:0] OP_SHR   = 4'h7;
  localparam logic [OPC_W-1:0] OP_ADDI  = 4'h8;
  localparam logic [OPC_W-1:0] OP_SUBI  = 4'h9;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'hA;
  localparam logic [OPC_W-1:0] OP_STORE = 4'hB;
  localparam logic [OPC_W-1:0] OP_BEQ   = 4'hC;
  localparam logic [OPC_W-1:0] OP_BNE   = 4'hD;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'hE;
  localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

  // Bit positions inside ex_ctrl, MSB first
  localparam int unsigned CTRL_WR_EN     = 8;
  localparam int unsigned CTRL_RAM_WE    = 7;
  localparam int unsigned CTRL_IMM_FLAG  = 6;
  localparam int unsigned CTRL_IS_LOAD   = 5;
  localparam int unsigned CTRL_IS_JUMP   = 4;
  localparam int unsigned CTRL_IS_BEQ    = 3;
  localparam int unsigned CTRL_IS_BNE    = 2;
  localparam int unsigned CTRL_WRITE_ALU = 1;
  localparam int unsigned CTRL_HALT      = 0;

  typedef struct packed {
    logic wr_en;
    logic ram_we;
    logic imm_flag;
    logic is_load;
    logic is_jump;
    logic is_beq;
    logic is_bne;
    logic write_alu;
    logic halt;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } state_e;

  // Instruction layout {opcode, ra, rb, rd, imm}, MSB first
  function automatic int unsigned instr_w(input int unsigned reg_aw, input int unsigned data_w);
    return OPC_W + 3 * reg_aw + data_w;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned reg_aw, input int unsigned data_w);
    return 3 * reg_aw + data_w;
  endfunction

  function automatic int unsigned ra_lsb(input int unsigned reg_aw, input int unsigned data_w);
    return 2 * reg_aw + data_w;
  endfunction

  function automatic int unsigned rb_lsb(input int unsigned reg_aw, input int unsigned data_w);
    return reg_aw + data_w;
  endfunction

  function automatic int unsigned rd_lsb(input int unsigned reg_aw, input int unsigned data_w);
    return reg_aw * 0 + data_w;
  endfunction

endpackage

// File: rtl/pipelined_decode_stage_if.sv
// Fetch/execute handshake bundle of the decode stage; master is the surrounding pipeline, slave the stage.
interface pipelined_decode_stage_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 4
) ();
  import protocore_isa_pkg::*;

  localparam int unsigned IW = instr_w(REG_AW, DATA_W);

  logic              if_valid;
  logic [IW-1:0]     if_instr;
  logic              if_ready;
  logic              flush;
  logic              resume;
  logic              ex_valid;
  logic              ex_ready;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic [REG_AW-1:0] ex_ra;
  logic [REG_AW-1:0] ex_rb;
  logic [REG_AW-1:0] ex_rd;
  logic [DATA_W-1:0] ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              halted;
  logic [31:0]       perf_issued;
  logic [31:0]       perf_stalls;

  modport master (
    output if_valid, if_instr, flush, resume, ex_ready,
    input  if_ready, ex_valid, ex_alu_op, ex_ra, ex_rb, ex_rd, ex_imm, ex_ctrl,
           halted, perf_issued, perf_stalls
  );

  modport slave (
    input  if_valid, if_instr, flush, resume, ex_ready,
    output if_ready, ex_valid, ex_alu_op, ex_ra, ex_rb, ex_rd, ex_imm, ex_ctrl,
           halted, perf_issued, perf_stalls
  );

endinterface

// File: rtl/pipelined_decode_stage_decode_comb.sv
// Pure combinational opcode -> control/field map; unused fields are forced to zero.
module decode_comb
  import protocore_isa_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned IW     = instr_w(REG_AW, DATA_W)
) (
  input  logic [IW-1:0]       instr,
  output logic [ALU_OP_W-1:0] alu_op_c,
  output logic [REG_AW-1:0]   ra_c,
  output logic [REG_AW-1:0]   rb_c,
  output logic [REG_AW-1:0]   rd_c,
  output logic [DATA_W-1:0]   imm_c,
  output ctrl_t               ctrl_c,
  output logic                reads_ra_c,
  output logic                reads_rb_c
);

  localparam int unsigned OP_LSB = op_lsb(REG_AW, DATA_W);
  localparam int unsigned RA_LSB = ra_lsb(REG_AW, DATA_W);
  localparam int unsigned RB_LSB = rb_lsb(REG_AW, DATA_W);
  localparam int unsigned RD_LSB = rd_lsb(REG_AW, DATA_W);

  logic [OPC_W-1:0]  op;
  logic [REG_AW-1:0] ra_f;
  logic [REG_AW-1:0] rb_f;
  logic [REG_AW-1:0] rd_f;
  logic [DATA_W-1:0] imm_f;
  logic use_ra, use_rb, use_rd, use_imm;

  assign op    = instr[OP_LSB +: OPC_W];
  assign ra_f  = instr[RA_LSB +: REG_AW];
  assign rb_f  = instr[RB_LSB +: REG_AW];
  assign rd_f  = instr[RD_LSB +: REG_AW];
  assign imm_f = instr[0 +: DATA_W];

  // Per-opcode field usage and control bits
  always_comb begin
    alu_op_c = '0;
    ctrl_c   = '0;
    use_ra   = 1'b0;
    use_rb   = 1'b0;
    use_rd   = 1'b0;
    use_imm  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        alu_op_c         = ALU_OP_W'(op[2:0]);
        use_ra           = 1'b1;
        use_rb           = 1'b1;
        use_rd           = 1'b1;
        ctrl_c.wr_en     = 1'b1;
        ctrl_c.write_alu = 1'b1;
      end
      OP_NOT, OP_SHL, OP_SHR: begin
        alu_op_c         = ALU_OP_W'(op[2:0]);
        use_ra           = 1'b1;
        use_rd           = 1'b1;
        ctrl_c.wr_en     = 1'b1;
        ctrl_c.write_alu = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        alu_op_c         = ALU_OP_W'({2'b00, op[0]});
        use_ra           = 1'b1;
        use_rd           = 1'b1;
        use_imm          = 1'b1;
        ctrl_c.imm_flag  = 1'b1;
        ctrl_c.wr_en     = 1'b1;
        ctrl_c.write_alu = 1'b1;
      end
      OP_LOAD: begin
        use_ra          = 1'b1;
        use_rd          = 1'b1;
        use_imm         = 1'b1;
        ctrl_c.imm_flag = 1'b1;
        ctrl_c.is_load  = 1'b1;
        ctrl_c.wr_en    = 1'b1;
      end
      OP_STORE: begin
        use_ra          = 1'b1;
        use_rb          = 1'b1;
        use_imm         = 1'b1;
        ctrl_c.imm_flag = 1'b1;
        ctrl_c.ram_we   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        alu_op_c      = ALU_OP_W'(1);
        use_ra        = 1'b1;
        use_rb        = 1'b1;
        ctrl_c.is_beq = (op == OP_BEQ);
        ctrl_c.is_bne = (op == OP_BNE);
      end
      OP_JMP: begin
        use_ra          = 1'b1;
        use_imm         = 1'b1;
        ctrl_c.imm_flag = 1'b1;
        ctrl_c.is_jump  = 1'b1;
      end
      OP_HALT: begin
        use_imm     = 1'b1;
        ctrl_c.halt = 1'b1;
      end
      default: ;
    endcase
  end

  assign ra_c       = use_ra  ? ra_f  : '0;
  assign rb_c       = use_rb  ? rb_f  : '0;
  assign rd_c       = use_rd  ? rd_f  : '0;
  assign imm_c      = use_imm ? imm_f : '0;
  assign reads_ra_c = use_ra;
  assign reads_rb_c = use_rb;

endmodule

// File: rtl/pipelined_decode_stage.sv
// Registered decode stage: load-use interlock, sticky HALT, flush, one-cycle latency.
// Optional DECODE_PERF_EN builds the issued/stall performance counters.
module pipelined_decode_stage
  import protocore_isa_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  pipelined_decode_stage_if.slave bus
);

  logic [ALU_OP_W-1:0] dec_alu_op;
  logic [REG_AW-1:0]   dec_ra, dec_rb, dec_rd;
  logic [DATA_W-1:0]   dec_imm;
  ctrl_t               dec_ctrl;
  logic                dec_reads_ra, dec_reads_rb;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              halted_q;

  logic                ex_valid_q;
  logic [ALU_OP_W-1:0] ex_alu_op_q;
  logic [REG_AW-1:0]   ex_ra_q, ex_rb_q, ex_rd_q;
  logic [DATA_W-1:0]   ex_imm_q;
  ctrl_t               ex_ctrl_q;

  logic hazard_c, if_ready_c, accept_c;

  decode_comb #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_decode (
    .instr      (bus.if_instr),
    .alu_op_c   (dec_alu_op),
    .ra_c       (dec_ra),
    .rb_c       (dec_rb),
    .rd_c       (dec_rd),
    .imm_c      (dec_imm),
    .ctrl_c     (dec_ctrl),
    .reads_ra_c (dec_reads_ra),
    .reads_rb_c (dec_reads_rb)
  );

  // Incoming op depends on a load still sitting in the output register
  assign hazard_c = bus.if_valid & ex_valid_q & ex_ctrl_q.is_load & ex_ctrl_q.wr_en &
                    ((dec_reads_ra & (dec_ra == ex_rd_q)) | (dec_reads_rb & (dec_rb == ex_rd_q)));

  assign if_ready_c = rst_n & (state_q == RUN) & ~bus.flush & ~hazard_c &
                      (~ex_valid_q | bus.ex_ready);
  assign accept_c   = bus.if_valid & if_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == HALTED);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (!bus.flush) begin
          if (accept_c && dec_ctrl.halt) begin
            state_d = HALTED;
          end else if (hazard_c && bus.ex_ready) begin
            state_d = STALL;
            cnt_d   = '0;
          end
        end
      end
      STALL: begin
        if (bus.flush || (cnt_q == CNT_W'(LOAD_LAT - 1))) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HALTED: begin
        if (bus.resume) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register: flush beats accept, fields hold while execute back-pressures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_alu_op_q <= '0;
      ex_ra_q     <= '0;
      ex_rb_q     <= '0;
      ex_rd_q     <= '0;
      ex_imm_q    <= '0;
      ex_ctrl_q   <= '0;
    end else if (bus.flush) begin
      ex_valid_q <= 1'b0;
    end else if (accept_c) begin
      ex_valid_q  <= 1'b1;
      ex_alu_op_q <= dec_alu_op;
      ex_ra_q     <= dec_ra;
      ex_rb_q     <= dec_rb;
      ex_rd_q     <= dec_rd;
      ex_imm_q    <= dec_imm;
      ex_ctrl_q   <= dec_ctrl;
    end else if (bus.ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign bus.if_ready  = if_ready_c;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_alu_op = ex_alu_op_q;
  assign bus.ex_ra     = ex_ra_q;
  assign bus.ex_rb     = ex_rb_q;
  assign bus.ex_rd     = ex_rd_q;
  assign bus.ex_imm    = ex_imm_q;
  assign bus.ex_ctrl   = ex_ctrl_q;
  assign bus.halted    = halted_q;

`ifdef DECODE_PERF_EN
  logic [31:0] issued_q, stalls_q;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      stalls_q <= '0;
    end else begin
      if (ex_valid_q && bus.ex_ready) issued_q <= issued_q + 32'd1;
      if (state_q == STALL)           stalls_q <= stalls_q + 32'd1;
    end
  end

  assign bus.perf_issued = issued_q;
  assign bus.perf_stalls = stalls_q;
`else
  assign bus.perf_issued = '0;
  assign bus.perf_stalls = '0;
`endif

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed bench for pipelined_decode_stage: decode table plus hazard, back-pressure, HALT, flush and reset sequences.
module tb_pipelined_decode_stage;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned NV     = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_decode_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  pipelined_decode_stage #(
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW),
    .LOAD_LAT (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [23:0] instr;
    logic [2:0]  alu;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rd;
    logic [7:0]  imm;
    logic [8:0]  ctrl;
  } vec_t;

  vec_t vecs [NV];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ex_valid"}, 32'(bus.ex_valid), 0);
    check({tag, "_if_ready"}, 32'(bus.if_ready), 0);
    check({tag, "_alu_op"},   32'(bus.ex_alu_op), 0);
    check({tag, "_ra"},       32'(bus.ex_ra), 0);
    check({tag, "_rb"},       32'(bus.ex_rb), 0);
    check({tag, "_rd"},       32'(bus.ex_rd), 0);
    check({tag, "_imm"},      32'(bus.ex_imm), 0);
    check({tag, "_ctrl"},     32'(bus.ex_ctrl), 0);
    check({tag, "_halted"},   32'(bus.halted), 0);
    check({tag, "_perf_iss"}, bus.perf_issued, 0);
    check({tag, "_perf_stl"}, bus.perf_stalls, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // {instr, alu_op, ra, rb, rd, imm, ctrl}
    vecs[0]  = '{24'h023100, 3'd0, 4'h2, 4'h3, 4'h1, 8'h00, 9'h102}; // ADD
    vecs[1]  = '{24'h1456FF, 3'd1, 4'h4, 4'h5, 4'h6, 8'h00, 9'h102}; // SUB
    vecs[2]  = '{24'h4A5B00, 3'd4, 4'hA, 4'h5, 4'hB, 8'h00, 9'h102}; // XOR
    vecs[3]  = '{24'h5789CC, 3'd5, 4'h7, 4'h0, 4'h9, 8'h00, 9'h102}; // NOT
    vecs[4]  = '{24'h712300, 3'd7, 4'h1, 4'h0, 4'h3, 8'h00, 9'h102}; // SHR
    vecs[5]  = '{24'h81F23C, 3'd0, 4'h1, 4'h0, 4'h2, 8'h3C, 9'h142}; // ADDI
    vecs[6]  = '{24'h93A405, 3'd1, 4'h3, 4'h0, 4'h4, 8'h05, 9'h142}; // SUBI
    vecs[7]  = '{24'hA2E505, 3'd0, 4'h2, 4'h0, 4'h5, 8'h05, 9'h160}; // LOAD
    vecs[8]  = '{24'hB67812, 3'd0, 4'h6, 4'h7, 4'h0, 8'h12, 9'h0C0}; // STORE
    vecs[9]  = '{24'hC12399, 3'd1, 4'h1, 4'h2, 4'h0, 8'h00, 9'h008}; // BEQ
    vecs[10] = '{24'hDABCDE, 3'd1, 4'hA, 4'hB, 4'h0, 8'h00, 9'h004}; // BNE
    vecs[11] = '{24'hE3457F, 3'd0, 4'h3, 4'h0, 4'h0, 8'h7F, 9'h050}; // JMP

    rst_n        = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    bus.flush    = 1'b0;
    bus.resume   = 1'b0;
    bus.ex_ready = 1'b1;
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Decode table, back-to-back accepts with execute always ready
    for (int i = 0; i < int'(NV); i++) begin
      bus.if_valid = 1'b1;
      bus.if_instr = vecs[i].instr;
      #1;
      check($sformatf("v%0d_if_ready", i), 32'(bus.if_ready), 1);
      step();
      check($sformatf("v%0d_ex_valid", i), 32'(bus.ex_valid), 1);
      check($sformatf("v%0d_alu_op", i), 32'(bus.ex_alu_op), 32'(vecs[i].alu));
      check($sformatf("v%0d_ra", i), 32'(bus.ex_ra), 32'(vecs[i].ra));
      check($sformatf("v%0d_rb", i), 32'(bus.ex_rb), 32'(vecs[i].rb));
      check($sformatf("v%0d_rd", i), 32'(bus.ex_rd), 32'(vecs[i].rd));
      check($sformatf("v%0d_imm", i), 32'(bus.ex_imm), 32'(vecs[i].imm));
      check($sformatf("v%0d_ctrl", i), 32'(bus.ex_ctrl), 32'(vecs[i].ctrl));
    end
    bus.if_valid = 1'b0;
    step();
    check("drain_ex_valid", 32'(bus.ex_valid), 0);

    // Load-use: LOAD r4=(r2+5) then ADD r5=r4+r1
    bus.if_valid = 1'b1;
    bus.if_instr = 24'hA20405;
    step();
    check("lu_load_rd", 32'(bus.ex_rd), 4);
    bus.if_instr = 24'h041500;
    #1;
    check("lu_hazard_if_ready", 32'(bus.if_ready), 0);
    step();
    check("lu_bubble_ex_valid", 32'(bus.ex_valid), 0);
    check("lu_stall_if_ready", 32'(bus.if_ready), 0);
    step();
    check("lu_run_if_ready", 32'(bus.if_ready), 1);
    check("lu_run_ex_valid", 32'(bus.ex_valid), 0);
    step();
    check("lu_add_ex_valid", 32'(bus.ex_valid), 1);
    check("lu_add_ra", 32'(bus.ex_ra), 4);
    check("lu_add_rd", 32'(bus.ex_rd), 5);
    bus.if_valid = 1'b0;
    step();

    // Back-pressure: SUB held for 3 cycles while OR waits
    bus.if_valid = 1'b1;
    bus.if_instr = 24'h1456FF;
    step();
    bus.ex_ready = 1'b0;
    bus.if_instr = 24'h312300;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d_if_ready", c), 32'(bus.if_ready), 0);
      check($sformatf("bp%0d_ex_valid", c), 32'(bus.ex_valid), 1);
      check($sformatf("bp%0d_rd", c), 32'(bus.ex_rd), 6);
      check($sformatf("bp%0d_ra", c), 32'(bus.ex_ra), 4);
      step();
    end
    bus.ex_ready = 1'b1;
    #1;
    check("bp_release_if_ready", 32'(bus.if_ready), 1);
    step();
    check("bp_next_rd", 32'(bus.ex_rd), 3);
    check("bp_next_alu_op", 32'(bus.ex_alu_op), 3);
    bus.if_valid = 1'b0;
    step();

    // HALT: sticky, survives flush, left by resume
    bus.if_valid = 1'b1;
    bus.if_instr = 24'hF000AA;
    step();
    check("halt_ex_valid", 32'(bus.ex_valid), 1);
    check("halt_ctrl", 32'(bus.ex_ctrl), 32'h001);
    check("halt_imm", 32'(bus.ex_imm), 32'hAA);
    check("halt_halted", 32'(bus.halted), 1);
    bus.if_instr = 24'h023100;
    #1;
    check("halt_if_ready", 32'(bus.if_ready), 0);
    step();
    check("halt_handoff_ex_valid", 32'(bus.ex_valid), 0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("halt_flush_halted", 32'(bus.halted), 1);
    bus.resume = 1'b1;
    #1;
    check("halt_resume_same_cycle_if_ready", 32'(bus.if_ready), 0);
    step();
    bus.resume = 1'b0;
    check("halt_resumed_halted", 32'(bus.halted), 0);
    #1;
    check("halt_resumed_if_ready", 32'(bus.if_ready), 1);
    step();
    check("halt_after_rd", 32'(bus.ex_rd), 1);
    bus.if_valid = 1'b0;
    bus.resume   = 1'b1;
    step();
    bus.resume = 1'b0;
    check("resume_in_run_halted", 32'(bus.halted), 0);
    check("resume_in_run_ex_valid", 32'(bus.ex_valid), 0);

    // Flush: same-cycle accept dropped, HALT accept suppressed, held op killed, STALL aborted
    bus.if_valid = 1'b1;
    bus.if_instr = 24'h1456FF;
    bus.flush    = 1'b1;
    #1;
    check("fl_if_ready", 32'(bus.if_ready), 0);
    step();
    check("fl_sub_dropped", 32'(bus.ex_valid), 0);
    bus.if_instr = 24'hF000AA;
    step();
    bus.flush = 1'b0;
    check("fl_halt_halted", 32'(bus.halted), 0);
    check("fl_halt_ex_valid", 32'(bus.ex_valid), 0);
    bus.ex_ready = 1'b0;
    bus.if_instr = 24'h023100;
    step();
    check("fl_held_ex_valid", 32'(bus.ex_valid), 1);
    bus.if_valid = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    check("fl_held_killed", 32'(bus.ex_valid), 0);
    bus.if_valid = 1'b1;
    bus.if_instr = 24'hA20405;
    step();
    bus.if_instr = 24'h041500;
    step();
    check("fl_stall_if_ready", 32'(bus.if_ready), 0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    #1;
    check("fl_stall_run_if_ready", 32'(bus.if_ready), 1);
    step();
    check("fl_stall_add_rd", 32'(bus.ex_rd), 5);
    bus.if_valid = 1'b0;
    step();

    // Fresh reset, then 4 issued ops with one stall cycle
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    bus.if_valid = 1'b1;
    bus.if_instr = 24'h023100;
    step();
    bus.if_instr = 24'hA20405;
    step();
    bus.if_instr = 24'h041500;
    step();
    step();
    step();
    bus.if_instr = 24'h1456FF;
    step();
    bus.if_valid = 1'b0;
    step();
    step();
`ifdef DECODE_PERF_EN
    check("perf_issued", bus.perf_issued, 4);
    check("perf_stalls", bus.perf_stalls, 1);
`else
    check("perf_issued_tied", bus.perf_issued, 0);
    check("perf_stalls_tied", bus.perf_stalls, 0);
`endif

    // Asynchronous reset in the middle of a STALL
    bus.if_valid = 1'b1;
    bus.if_instr = 24'hA20405;
    step();
    bus.if_instr = 24'h041500;
    step();
    check("rs_in_stall_if_ready", 32'(bus.if_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_stall_reset");
    bus.if_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("rs_after_ex_valid", 32'(bus.ex_valid), 0);
    check("rs_after_if_ready", 32'(bus.if_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
